// File: rtl/puf_scan_arbiter.sv
// -----------------------------------------------------------------------------
// puf_scan_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer that shares a single PUF counter /
//   scan-enable engine between NUM_REQ requesters. A granted requester's
//   target count is latched and sent to the engine with a one-cycle start.
//   When the engine signals count_done, the captured counter value is returned
//   to the requester and priority rotates past it.
//
// Optional feature (compile-time macro PUF_ARB_TIMEOUT_EN):
//   Adds a WAIT-state watchdog. If the engine has not signalled count_done
//   within pc_target + TIMEOUT_SLACK WAIT cycles, the service is closed with
//   resp_valid and resp_err both pulsed. Without the macro, WAIT persists until
//   count_done arrives and resp_err is tied low.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   i_req            level request per requester, held until its response
//   i_req_target     per-requester target count, slice i = [i*CNT_W +: CNT_W]
//   o_grant          one-hot grant, high from ISSUE through WAIT
//   o_resp_valid     one-cycle completion pulse
//   o_resp_id        index of the completed requester
//   o_resp_count     engine counter captured at completion
//   o_resp_err       one-cycle timeout flag alongside o_resp_valid
//   o_busy           high whenever the FSM is not idle
//   o_pc_start       one-cycle start to the engine
//   o_pc_target      target count to the engine, stable from ISSUE through WAIT
//   i_pc_count_done  engine count_done
//   i_pc_counter     engine counter value
//   i_pc_scan_enable engine scan_enable (monitored only)
// -----------------------------------------------------------------------------
module puf_scan_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TIMEOUT_SLACK = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*CNT_W-1:0]   i_req_target,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_resp_id,
  output logic [CNT_W-1:0]           o_resp_count,
  output logic                       o_resp_err,
  output logic                       o_busy,
  output logic                       o_pc_start,
  output logic [CNT_W-1:0]           o_pc_target,
  input  logic                       i_pc_count_done,
  input  logic [CNT_W-1:0]           i_pc_counter,
  input  logic                       i_pc_scan_enable
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e             r_state, w_state_nxt;
  logic [IdW-1:0]     r_rr, w_rr_nxt;
  logic [IdW-1:0]     r_cur, w_cur_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_resp_valid, w_resp_valid_nxt;
  logic [IdW-1:0]     r_resp_id, w_resp_id_nxt;
  logic [CNT_W-1:0]   r_resp_count, w_resp_count_nxt;
  logic               r_resp_err, w_resp_err_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_pc_start, w_pc_start_nxt;
  logic [CNT_W-1:0]   r_pc_target, w_pc_target_nxt;

  logic [NUM_REQ-1:0] w_upper;
  logic [IdW-1:0]     w_pick;
  logic [CNT_W-1:0]   w_pick_target;
  logic [IdW-1:0]     w_rr_after;
  logic               w_timeout;
  logic               w_unused;

  // Round-robin pick: lowest set request at or above the pointer, otherwise
  // wrap around to the lowest set request overall.
  always_comb begin
    w_upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_upper[i] = i_req[i] && (IdW'(i) >= r_rr);
    end
    w_pick = '0;
    if (|w_upper) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (w_upper[i]) w_pick = IdW'(i);
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_req[i]) w_pick = IdW'(i);
      end
    end
  end

  // Constant-index mux keeps the slice select width-clean.
  always_comb begin
    w_pick_target = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IdW'(i)) w_pick_target = i_req_target[i*CNT_W +: CNT_W];
    end
  end

  assign w_rr_after = (r_cur == IdW'(NUM_REQ - 1)) ? '0 : r_cur + IdW'(1);

`ifdef PUF_ARB_TIMEOUT_EN
  logic [CNT_W:0]   r_wd;
  logic [CNT_W+1:0] w_wd_inc;
  logic [CNT_W+1:0] w_limit;

  assign w_wd_inc  = {1'b0, r_wd} + (CNT_W + 2)'(1);
  assign w_limit   = {2'b00, r_pc_target} + (CNT_W + 2)'(TIMEOUT_SLACK);
  // count_done in the same cycle takes precedence over the watchdog.
  assign w_timeout = (r_state == StWait) && !i_pc_count_done && (w_wd_inc >= w_limit);
  assign w_unused  = i_pc_scan_enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (r_state == StIssue) begin
      r_wd <= '0;
    end else if (r_state == StWait) begin
      r_wd <= w_wd_inc[CNT_W:0];
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^{i_pc_scan_enable, TIMEOUT_SLACK[0]};
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_rr_nxt         = r_rr;
    w_cur_nxt        = r_cur;
    w_grant_nxt      = r_grant;
    w_resp_valid_nxt = 1'b0;
    w_resp_id_nxt    = r_resp_id;
    w_resp_count_nxt = r_resp_count;
    w_resp_err_nxt   = 1'b0;
    w_busy_nxt       = r_busy;
    w_pc_start_nxt   = 1'b0;
    w_pc_target_nxt  = r_pc_target;

    case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_nxt     = StIssue;
          w_cur_nxt       = w_pick;
          w_grant_nxt     = NUM_REQ'(1) << w_pick;
          w_pc_target_nxt = w_pick_target;
          w_pc_start_nxt  = 1'b1;
          w_busy_nxt      = 1'b1;
        end
      end
      StIssue: begin
        w_state_nxt = StWait;
      end
      StWait: begin
        if (i_pc_count_done || w_timeout) begin
          w_state_nxt      = StIdle;
          w_grant_nxt      = '0;
          w_busy_nxt       = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = w_timeout;
          w_resp_id_nxt    = r_cur;
          w_resp_count_nxt = i_pc_counter;
          w_rr_nxt         = w_rr_after;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_rr         <= '0;
      r_cur        <= '0;
      r_grant      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_count <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
      r_pc_start   <= 1'b0;
      r_pc_target  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr         <= w_rr_nxt;
      r_cur        <= w_cur_nxt;
      r_grant      <= w_grant_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_id    <= w_resp_id_nxt;
      r_resp_count <= w_resp_count_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_busy       <= w_busy_nxt;
      r_pc_start   <= w_pc_start_nxt;
      r_pc_target  <= w_pc_target_nxt;
    end
  end

  assign o_grant      = r_grant;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_count = r_resp_count;
  assign o_resp_err   = r_resp_err;
  assign o_busy       = r_busy;
  assign o_pc_start   = r_pc_start;
  assign o_pc_target  = r_pc_target;

endmodule

// File: tb/tb_puf_scan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_puf_scan_arbiter
//
// Self-checking bench for puf_scan_arbiter (NUM_REQ=4, CNT_W=16). A small
// behavioural engine answers pc_start with count_done T+1 edges later and
// counter=T; it can be swapped for a manually driven stub. Expected responses
// are queued when requests are driven and popped by a monitor on resp_valid.
// Define PUF_ARB_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_puf_scan_arbiter;

  localparam int NR = 4;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*CW-1:0] req_target;
  logic [NR-1:0]    grant;
  logic             resp_valid;
  logic [1:0]       resp_id;
  logic [CW-1:0]    resp_count;
  logic             resp_err;
  logic             busy;
  logic             pc_start;
  logic [CW-1:0]    pc_target;
  logic             pc_count_done;
  logic [CW-1:0]    pc_counter;
  logic             pc_scan_enable;

  always #5 clk = ~clk;

  puf_scan_arbiter #(
    .NUM_REQ      (NR),
    .CNT_W        (CW),
    .TIMEOUT_SLACK(8)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req           (req),
    .i_req_target    (req_target),
    .o_grant         (grant),
    .o_resp_valid    (resp_valid),
    .o_resp_id       (resp_id),
    .o_resp_count    (resp_count),
    .o_resp_err      (resp_err),
    .o_busy          (busy),
    .o_pc_start      (pc_start),
    .o_pc_target     (pc_target),
    .i_pc_count_done (pc_count_done),
    .i_pc_counter    (pc_counter),
    .i_pc_scan_enable(pc_scan_enable)
  );

  // Engine model and manual stub.
  bit            eng_off;
  logic          man_done;
  logic [CW-1:0] man_cnt;
  logic          eng_run;
  logic          eng_done;
  logic [CW-1:0] eng_cnt;
  logic [CW-1:0] eng_tgt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_run  <= 1'b0;
      eng_done <= 1'b0;
      eng_cnt  <= '0;
      eng_tgt  <= '0;
    end else begin
      eng_done <= 1'b0;
      if (pc_start) begin
        eng_run <= 1'b1;
        eng_cnt <= '0;
        eng_tgt <= pc_target;
      end else if (eng_run) begin
        if (eng_cnt == eng_tgt) begin
          eng_done <= 1'b1;
          eng_run  <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt + 16'd1;
        end
      end
    end
  end

  assign pc_count_done  = eng_off ? man_done : eng_done;
  assign pc_counter     = eng_off ? man_cnt : eng_cnt;
  assign pc_scan_enable = eng_run;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] tgt;
    logic [1:0]  id;
    bit          drop;
    bit          chg;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [15:0] cnt, input logic err);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    e.err = err;
    sb.push_back(e);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=resp id %0d required=no response", resp_id);
      end else begin
        e = sb.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_count", 32'(resp_count), 32'(e.cnt));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic set_all_targets(input logic [15:0] t);
    for (int k = 0; k < NR; k++) req_target[k*CW +: CW] = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_flags"}, 32'({resp_valid, resp_err, busy, pc_start}), 0);
    chk({tag, "_resp_id"}, 32'(resp_id), 0);
    chk({tag, "_resp_count"}, 32'(resp_count), 0);
    chk({tag, "_pc_target"}, 32'(pc_target), 0);
  endtask

  // One complete service through the attached engine.
  task automatic run_one(input vec_t v);
    int n;
    bit got;
    @(negedge clk);
    set_all_targets(v.tgt);
    req = v.req;
    push_exp(v.id, v.tgt, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (grant != '0) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 1);
    chk("grant", 32'(grant), 32'(4'b0001 << v.id));
    chk("pc_start_hi", 32'(pc_start), 1);
    chk("busy_hi", 32'(busy), 1);
    chk("pc_target", 32'(pc_target), 32'(v.tgt));
    if (v.drop) req = '0;
    if (v.chg) set_all_targets(16'd50);
    @(negedge clk);
    chk("pc_start_lo", 32'(pc_start), 0);
    chk("grant_hold", 32'(grant), 32'(4'b0001 << v.id));
    chk("pc_target_hold", 32'(pc_target), 32'(v.tgt));
    n   = 1;
    got = 1'b0;
    while (!got && n < int'(v.tgt) + 20) begin
      if (resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("resp_seen", 32'(got), 1);
    chk("latency", 32'(n), 32'(int'(v.tgt) + 3));
    chk("grant_clr", 32'(grant), 0);
    chk("busy_lo", 32'(busy), 0);
    req = '0;
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 0);
  endtask

  // Held request pattern; drops req on the nexp-th response.
  task automatic stream(input logic [3:0] r, input int nexp, input string tag);
    int nresp;
    int bad;
    bit pend;
    nresp = 0;
    bad   = 0;
    pend  = 1'b0;
    @(negedge clk);
    req = r;
    for (int c = 0; c < 400 && nresp < nexp; c++) begin
      @(negedge clk);
      if (pend) begin
        chk({tag, "_regrant"}, 32'(grant != '0), 1);
        pend = 1'b0;
      end
      if ($countones(grant) > 1) bad++;
      if (resp_valid) begin
        nresp++;
        chk({tag, "_gap"}, 32'(grant), 0);
        if (nresp == nexp) req = '0;
        else pend = 1'b1;
      end
    end
    chk({tag, "_nresp"}, 32'(nresp), 32'(nexp));
    chk({tag, "_onehot"}, 32'(bad), 0);
  endtask

  vec_t vecs[7];

  initial begin
    bit got;
    int n;
    // req, tgt, expected id, drop req after grant, change target after grant
    vecs[0] = '{4'b0010, 16'd5,  2'd1, 1'b0, 1'b0};
    vecs[1] = '{4'b0100, 16'd0,  2'd2, 1'b0, 1'b0};
    vecs[2] = '{4'b0011, 16'd3,  2'd0, 1'b0, 1'b0};
    vecs[3] = '{4'b1001, 16'd4,  2'd3, 1'b1, 1'b0};
    vecs[4] = '{4'b0001, 16'd10, 2'd0, 1'b0, 1'b1};
    vecs[5] = '{4'b0101, 16'd2,  2'd2, 1'b0, 1'b0};
    vecs[6] = '{4'b1111, 16'd1,  2'd3, 1'b0, 1'b0};

    rst_n      = 1'b0;
    req        = '0;
    req_target = '0;
    eng_off    = 1'b0;
    man_done   = 1'b0;
    man_cnt    = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_one(vecs[i]);

    // Fairness with all requesters held.
    do_reset();
    for (int k = 0; k < NR; k++) req_target[k*CW +: CW] = 16'(3 + k);
    for (int k = 0; k < 6; k++) push_exp(2'(k % 4), 16'(3 + (k % 4)), 1'b0);
    stream(4'b1111, 6, "fair");

    // Persistent single requester, then the pointer must have moved past it.
    do_reset();
    set_all_targets(16'd1);
    push_exp(2'd0, 16'd1, 1'b0);
    push_exp(2'd0, 16'd1, 1'b0);
    stream(4'b0001, 2, "persist");
    push_exp(2'd1, 16'd1, 1'b0);
    stream(4'b0011, 1, "rr_adv");

    // Reset in the middle of a long WAIT.
    do_reset();
    @(negedge clk);
    set_all_targets(16'd100);
    req = 4'b0001;
    repeat (20) @(negedge clk);
    chk("midwait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    req   = '0;
    sb.delete();
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_one('{4'b1000, 16'd2, 2'd3, 1'b0, 1'b0});

    // Manual stub: done ignored in IDLE and ISSUE, full-scale target.
    eng_off = 1'b1;
    @(negedge clk);
    man_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_done_busy", 32'(busy), 0);
    chk("idle_done_resp", 32'(resp_valid), 0);
    man_done = 1'b0;
    set_all_targets(16'hFFFF);
    req = 4'b0100;
    push_exp(2'd2, 16'hFFFF, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (grant != '0) got = 1'b1;
    end
    chk("max_grant", 32'(grant), 32'(4'b0100));
    chk("max_pc_target", 32'(pc_target), 32'hFFFF);
    man_done = 1'b1;
    man_cnt  = 16'h1234;
    @(negedge clk);
    man_done = 1'b0;
    chk("issue_done_resp", 32'(resp_valid), 0);
    repeat (3) @(negedge clk);
    chk("issue_done_busy", 32'(busy), 1);
    chk("issue_done_resp2", 32'(resp_valid), 0);
    man_cnt  = 16'hFFFF;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    req      = '0;
    chk("max_resp", 32'(resp_valid), 1);
    chk("max_busy", 32'(busy), 0);
    @(negedge clk);

`ifdef PUF_ARB_TIMEOUT_EN
    // Engine never answers: watchdog closes each service.
    do_reset();
    set_all_targets(16'd4);
    man_cnt = 16'd7;
    push_exp(2'd1, 16'd7, 1'b1);
    push_exp(2'd2, 16'd7, 1'b1);
    @(negedge clk);
    req = 4'b0110;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (grant != '0) got = 1'b1;
    end
    chk("to_grant", 32'(grant), 32'(4'b0010));
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (resp_valid) got = 1'b1;
    end
    chk("to_latency", 32'(n), 13);
    chk("to_err", 32'(resp_err), 1);
    req = 4'b0100;
    @(negedge clk);
    chk("to_next_grant", 32'(grant), 32'(4'b0100));
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    chk("to_second", 32'(got), 1);
    req = '0;
    @(negedge clk);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
